// File: rtl/nvdla_pdp_rdma_grp_status_pkg.sv
// Shared PDP RDMA package: group status encodings and small helpers used by the
// register-group ping-pong logic.
package nvdla_pdp_rdma_grp_status_pkg;

    localparam int NUM_GRP = 2;

    typedef enum logic [1:0] {
        GRP_IDLE    = 2'd0,
        GRP_RUNNING = 2'd1,
        GRP_PENDING = 2'd2
    } grp_status_e;

    // One-hot completion vector for a single group index.
    function automatic logic [NUM_GRP-1:0] grpOneHot(input logic grp);
        return grp ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/nvdla_pdp_rdma_grp_slot.sv
// One register group: its op_en flop and the combinational status decode.
module nvdla_pdp_rdma_grp_slot
    import nvdla_pdp_rdma_grp_status_pkg::*;
(
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rstn,
    input  logic       set_i,
    input  logic       clr_i,
    input  logic       active_i,
    output logic       opEn_o,
    output logic [1:0] status_o
);

    logic        opEn_q;
    logic        opEn_d;
    grp_status_e status;

    // A re-arm landing in the same cycle as this group's completion wins.
    always_comb begin
        opEn_d = opEn_q;
        if (clr_i) opEn_d = 1'b0;
        if (set_i) opEn_d = 1'b1;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) opEn_q <= 1'b0;
        else                  opEn_q <= opEn_d;
    end

    always_comb begin
        status = GRP_IDLE;
        if (opEn_q) status = active_i ? GRP_RUNNING : GRP_PENDING;
    end

    assign opEn_o   = opEn_q;
    assign status_o = status;

endmodule

// File: rtl/nvdla_pdp_rdma_grp_status.sv
// PDP RDMA two-group ping-pong tracker: arms groups on D_OP_ENABLE writes, hands
// ownership to the datapath, and reports completions, errors and a layer count.
module nvdla_pdp_rdma_grp_status
    import nvdla_pdp_rdma_grp_status_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             producer,
    input  logic             op_en_trigger,
    input  logic             dp_done,
    output logic             consumer,
    output logic [1:0]       status_0,
    output logic [1:0]       status_1,
    output logic             dp_op_en,
    output logic [1:0]       intr_done,
    output logic             err_unexp_done,
    output logic [CNT_W-1:0] layer_cnt
);

    logic                 consumer_q, consumer_d;
    logic [NUM_GRP-1:0]   intrDone_q, intrDone_d;
    logic                 errUnexp_q, errUnexp_d;
    logic [CNT_W-1:0]     layerCnt_q, layerCnt_d;

    logic [NUM_GRP-1:0]   slotSet;
    logic [NUM_GRP-1:0]   slotClr;
    logic [NUM_GRP-1:0]   slotActive;
    logic [NUM_GRP-1:0]   opEn;
    logic [1:0]           slotStatus [NUM_GRP];
    logic                 doneOk;

    assign doneOk = dp_done && opEn[consumer_q];

    for (genvar g = 0; g < NUM_GRP; g++) begin : gSlot
        assign slotSet[g]    = op_en_trigger && (producer == 1'(g));
        assign slotClr[g]    = doneOk && (consumer_q == 1'(g));
        assign slotActive[g] = (consumer_q == 1'(g));

        nvdla_pdp_rdma_grp_slot uSlot (
            .nvdla_core_clk  (nvdla_core_clk),
            .nvdla_core_rstn (nvdla_core_rstn),
            .set_i           (slotSet[g]),
            .clr_i           (slotClr[g]),
            .active_i        (slotActive[g]),
            .opEn_o          (opEn[g]),
            .status_o        (slotStatus[g])
        );
    end

    // An unarmed completion only raises the sticky error; nothing else moves.
    always_comb begin
        consumer_d = consumer_q;
        intrDone_d = '0;
        errUnexp_d = errUnexp_q;
        layerCnt_d = layerCnt_q;
        if (doneOk) begin
            consumer_d = ~consumer_q;
            intrDone_d = grpOneHot(consumer_q);
            layerCnt_d = layerCnt_q + CNT_W'(1);
        end else if (dp_done) begin
            errUnexp_d = 1'b1;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            consumer_q <= 1'b0;
            intrDone_q <= '0;
            errUnexp_q <= 1'b0;
            layerCnt_q <= '0;
        end else begin
            consumer_q <= consumer_d;
            intrDone_q <= intrDone_d;
            errUnexp_q <= errUnexp_d;
            layerCnt_q <= layerCnt_d;
        end
    end

    assign consumer       = consumer_q;
    assign status_0       = slotStatus[0];
    assign status_1       = slotStatus[1];
    assign dp_op_en       = opEn[consumer_q];
    assign intr_done      = intrDone_q;
    assign err_unexp_done = errUnexp_q;
    assign layer_cnt      = layerCnt_q;

endmodule

// File: tb/tb_nvdla_pdp_rdma_grp_status.sv
// Scoreboard bench for the PDP RDMA group tracker: the driver pushes expected
// post-edge outputs, the monitor pops and compares just after each rising edge.
module tb_nvdla_pdp_rdma_grp_status;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic             consumer;
        logic [1:0]       status0;
        logic [1:0]       status1;
        logic             dpOpEn;
        logic [1:0]       intr;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    logic             clk;
    logic             rstn;
    logic             producer;
    logic             opEnTrigger;
    logic             dpDone;
    logic             consumer;
    logic [1:0]       status0;
    logic [1:0]       status1;
    logic             dpOpEn;
    logic [1:0]       intrDone;
    logic             errUnexp;
    logic [CNT_W-1:0] layerCnt;

    obs_t   expQ [$];
    string  tagQ [$];
    int     compared   = 0;
    int     mismatched = 0;
    bit     stimDone   = 0;

    logic [1:0]       mOpEn;
    logic             mCons;
    logic             mErr;
    logic [CNT_W-1:0] mCnt;
    logic [1:0]       mIntr;

    nvdla_pdp_rdma_grp_status #(.CNT_W(CNT_W)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .producer        (producer),
        .op_en_trigger   (opEnTrigger),
        .dp_done         (dpDone),
        .consumer        (consumer),
        .status_0        (status0),
        .status_1        (status1),
        .dp_op_en        (dpOpEn),
        .intr_done       (intrDone),
        .err_unexp_done  (errUnexp),
        .layer_cnt       (layerCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected status of one group from the reference state.
    function automatic logic [1:0] expStatus(input logic armed, input logic isActive);
        if (!armed) return 2'd0;
        return isActive ? 2'd1 : 2'd2;
    endfunction

    function automatic obs_t snapshot();
        obs_t o;
        o.consumer = mCons;
        o.status0  = expStatus(mOpEn[0], mCons == 1'b0);
        o.status1  = expStatus(mOpEn[1], mCons == 1'b1);
        o.dpOpEn   = mOpEn[mCons];
        o.intr     = mIntr;
        o.err      = mErr;
        o.cnt      = mCnt;
        return o;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic applyStimulus(input logic prod, input logic trig, input logic done, input string tag);
        logic armedDone;
        @(negedge clk);
        producer    = prod;
        opEnTrigger = trig;
        dpDone      = done;
        armedDone   = done && mOpEn[mCons];
        mIntr       = 2'b00;
        if (armedDone) begin
            mOpEn[mCons] = 1'b0;
            mIntr        = mCons ? 2'b10 : 2'b01;
            mCons        = ~mCons;
            mCnt         = mCnt + 1'b1;
        end else if (done) begin
            mErr = 1'b1;
        end
        if (trig) mOpEn[prod] = 1'b1;
        expQ.push_back(snapshot());
        tagQ.push_back(tag);
    endtask

    task automatic applyReset(input string tag);
        @(negedge clk);
        rstn        = 1'b0;
        producer    = 1'b0;
        opEnTrigger = 1'b0;
        dpDone      = 1'b0;
        mOpEn = 2'b00; mCons = 1'b0; mErr = 1'b0; mCnt = '0; mIntr = 2'b00;
        expQ.push_back(snapshot());
        tagQ.push_back(tag);
        @(negedge clk);
        rstn = 1'b1;
        expQ.push_back(snapshot());
        tagQ.push_back({tag, "_release"});
    endtask

    task automatic checkOutput(input obs_t exp, input string tag);
        obs_t act;
        act.consumer = consumer;
        act.status0  = status0;
        act.status1  = status1;
        act.dpOpEn   = dpOpEn;
        act.intr     = intrDone;
        act.err      = errUnexp;
        act.cnt      = layerCnt;
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got cons=%0d s0=%0d s1=%0d en=%0d intr=%b err=%0d cnt=%0d, want cons=%0d s0=%0d s1=%0d en=%0d intr=%b err=%0d cnt=%0d",
                     tag, act.consumer, act.status0, act.status1, act.dpOpEn, act.intr, act.err, act.cnt,
                     exp.consumer, exp.status0, exp.status1, exp.dpOpEn, exp.intr, exp.err, exp.cnt);
        end
    endtask

    // Monitor: one queued expectation is consumed per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front(), tagQ.pop_front());
        end
    end

    initial begin
        rstn = 1'b0; producer = 1'b0; opEnTrigger = 1'b0; dpDone = 1'b0;
        mOpEn = 2'b00; mCons = 1'b0; mErr = 1'b0; mCnt = '0; mIntr = 2'b00;

        applyReset("reset");

        applyStimulus(1'b0, 1'b1, 1'b0, "arm_g0");
        applyStimulus(1'b1, 1'b1, 1'b0, "arm_g1");
        applyStimulus(1'b0, 1'b0, 1'b1, "done_g0");
        applyStimulus(1'b0, 1'b0, 1'b0, "intr_clears");
        applyStimulus(1'b0, 1'b0, 1'b1, "done_g1");

        applyStimulus(1'b0, 1'b1, 1'b0, "arm_g0_again");
        applyStimulus(1'b0, 1'b1, 1'b1, "rearm_same_done");
        applyStimulus(1'b0, 1'b0, 1'b0, "pending_hold");
        applyStimulus(1'b1, 1'b1, 1'b0, "arm_g1_run");
        applyStimulus(1'b0, 1'b1, 1'b1, "done_g1_ignored_trig");
        applyStimulus(1'b0, 1'b0, 1'b1, "done_g0_to_idle");

        applyStimulus(1'b1, 1'b1, 1'b0, "arm_g1_b");
        applyStimulus(1'b0, 1'b1, 1'b1, "done_with_other_trig");
        applyStimulus(1'b0, 1'b0, 1'b1, "done_g0_b");

        applyStimulus(1'b0, 1'b0, 1'b1, "unexp_done");
        applyStimulus(1'b0, 1'b0, 1'b0, "err_sticky");
        applyStimulus(1'b0, 1'b1, 1'b0, "err_sticky_arm");

        applyReset("reset_clears_err");
        applyStimulus(1'b0, 1'b1, 1'b0, "mid_arm0");
        applyStimulus(1'b1, 1'b1, 1'b0, "mid_arm1");
        applyStimulus(1'b0, 1'b0, 1'b1, "mid_done0");
        applyStimulus(1'b0, 1'b1, 1'b0, "mid_pend0");
        applyReset("reset_mid_layer");

        for (int i = 0; i < 16; i++) begin
            applyStimulus(mCons, 1'b1, 1'b0, $sformatf("wrap_arm%0d", i));
            applyStimulus(1'b0, 1'b0, 1'b1, $sformatf("wrap_done%0d", i));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, "wrap_final");
        stimDone = 1'b1;
    end

    initial begin
        wait (stimDone);
        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no end of stimulus, want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/nvdla_pdp_rdma_grp_status.md
NVDLA_PDP_RDMA_GRP_STATUS -- requirements
Module: nvdla_pdp_rdma_grp_status

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-layer counter.
REQ-002 SHALL have port nvdla_core_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port nvdla_core_rstn  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port producer  input  1  software-selected register group for the current D_OP_ENABLE write.
REQ-005 SHALL have port op_en_trigger  input  1  one-cycle pulse: D_OP_ENABLE written with 1 for group = producer.
REQ-006 SHALL have port dp_done  input  1  one-cycle pulse from the RDMA datapath: active layer complete.
REQ-007 SHALL have port consumer  output  1  group currently owned by the datapath.
REQ-008 SHALL have port status_0  output  2  group 0 status: 0 IDLE, 1 RUNNING, 2 PENDING; 3 never driven.
REQ-009 SHALL have port status_1  output  2  group 1 status, same encoding.
REQ-010 SHALL have port dp_op_en  output  1  level: active group armed, datapath may run.
REQ-011 SHALL have port intr_done  output  2  one-cycle completion pulse; bit g = group g.
REQ-012 SHALL have port err_unexp_done  output  1  sticky: dp_done received with no armed active group.
REQ-013 SHALL have port layer_cnt  output  CNT_W  count of completed layers.

Function
REQ-014 SHALL hold per-group flop op_en[g]; op_en_trigger sets op_en[producer] to 1 at the next edge.
REQ-015 SHALL ignore op_en_trigger when op_en[producer] is already 1 and no same-cycle completion of that group occurs.
REQ-016 SHALL drive status_g combinationally: IDLE if op_en[g]=0; RUNNING if op_en[g]=1 and consumer=g; PENDING if op_en[g]=1 and consumer!=g.
REQ-017 SHALL drive dp_op_en = op_en[consumer], combinational.
REQ-018 On dp_done with op_en[consumer]=1, SHALL at the next edge clear op_en[consumer], toggle consumer, increment layer_cnt, and assert intr_done[old consumer] for exactly one cycle.
REQ-019 layer_cnt SHALL wrap from all-ones to 0 without any flag.
REQ-020 On dp_done with op_en[consumer]=0, SHALL set err_unexp_done at the next edge and change no other state.
REQ-021 Simultaneous trigger to group g and completion of group g: op_en[g] SHALL end 1 (re-armed), consumer still toggles, so group g becomes PENDING.
REQ-022 Simultaneous trigger to the non-active group and completion: both actions SHALL apply; that group becomes RUNNING next cycle.
REQ-023 A PENDING group SHALL become RUNNING in the same cycle consumer toggles onto it, with no extra bubble.
REQ-024 intr_done SHALL never have both bits set in the same cycle.
REQ-025 err_unexp_done SHALL clear only on reset.

Reset
REQ-026 On nvdla_core_rstn low: op_en[1:0]=0, consumer=0, intr_done=0, err_unexp_done=0, layer_cnt=0; hence status_0=status_1=0, dp_op_en=0.
REQ-027 Reset asserted mid-layer SHALL abandon the layer with no intr_done pulse; first edge after deassertion behaves as post-reset idle.

Structure
REQ-028 Status encodings (IDLE/RUNNING/PENDING) SHALL be constants in the shared PDP RDMA package used by the register blocks.
REQ-029 One sub-module, nvdla_pdp_rdma_grp_slot (op_en flop + status decode), SHALL be instantiated twice, once per group.
REQ-030 All flops SHALL reside on nvdla_core_clk with asynchronous active-low reset; no latches.

Verification
REQ-031 Reset, then trigger with producer=0 -> next cycle status_0=1, status_1=0, dp_op_en=1, consumer=0.
REQ-032 Arm group 0 then group 1 (producer=1), then dp_done -> next cycle intr_done=2'b01, consumer=1, status_0=0, status_1=1, layer_cnt=1.
REQ-033 Group 0 RUNNING; trigger producer=0 in same cycle as dp_done -> consumer=1, status_0=2 (PENDING), intr_done[0]=1 one cycle.
REQ-034 dp_done with both groups IDLE -> err_unexp_done=1 and stays 1; consumer, layer_cnt unchanged.
REQ-035 CNT_W=4, 16 alternating completions -> layer_cnt returns to 0, consumer=0, 16 single-bit intr_done pulses alternating bits.
REQ-036 Assert reset while group 1 RUNNING and group 0 PENDING -> all outputs at REQ-026 values, no intr_done pulse.
